// File: rtl/pc_control.sv
// Program counter and branch resolution for the 16-bit core.
// Resolves B/BR/PCS/HLT against the ALU flags and holds the architectural PC.
module pc_control #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic        stall,
    input  logic [3:0]  opcode,
    input  logic [2:0]  cond,
    input  logic [8:0]  imm9,
    input  logic [15:0] br_target,
    input  logic        N_Flag,
    input  logic        Z_Flag,
    input  logic        V_Flag,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        taken,
    output logic        halted,
    output logic [15:0] branch_count
);

    localparam int unsigned PC_W  = 16;
    localparam int unsigned CNT_W = 16;

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  branch_count_q, branch_count_d;

    logic              cond_true;
    logic              is_branch;
    logic              accept;
    logic [PC_W-1:0]   b_target;
    logic [PC_W-1:0]   br_aligned;

    // Condition code evaluation against the registered ALU flags.
    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            3'b000: cond_true = ~Z_Flag;
            3'b001: cond_true = Z_Flag;
            3'b010: cond_true = ~Z_Flag & ~N_Flag;
            3'b011: cond_true = N_Flag;
            3'b100: cond_true = Z_Flag | (~Z_Flag & ~N_Flag);
            3'b101: cond_true = N_Flag | Z_Flag;
            3'b110: cond_true = V_Flag;
            3'b111: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign is_branch  = (opcode == OP_B) || (opcode == OP_BR);
    assign taken      = instr_valid & (state_q == ST_RUN) & is_branch & cond_true;
    assign accept     = instr_valid & ~stall & (state_q == ST_RUN);
    assign pc_plus2   = pc_q + PC_W'(2);
    // Offset counts instructions, so it is scaled by two bytes.
    assign b_target   = pc_plus2 + {{6{imm9[8]}}, imm9, 1'b0};
    assign br_aligned = {br_target[PC_W-1:1], 1'b0};

    // Next-state, next-PC and branch counter selection.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        branch_count_d = branch_count_q;

        if (accept) begin
            unique case (opcode)
                OP_B:    pc_d = taken ? b_target : pc_plus2;
                OP_BR:   pc_d = taken ? br_aligned : pc_plus2;
                OP_HLT:  state_d = ST_HALTED;
                default: pc_d = pc_plus2;
            endcase

            if (taken && (branch_count_q != CNT_MAX)) begin
                branch_count_d = branch_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            pc_q           <= RESET_PC;
            branch_count_q <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            branch_count_q <= branch_count_d;
        end
    end

    assign pc           = pc_q;
    assign halted       = (state_q == ST_HALTED);
    assign branch_count = branch_count_q;

endmodule
